// File: rtl/multi_channel_scoreboard_pkg.sv
// Shared types and helpers for the multi-channel magic-packet scoreboard.
// Latency: n/a (types, constants and a combinational slice helper only).
// Backpressure: n/a.
package sb_pkg;

    // Tracking FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_TRACK = 2'd2,
        ST_DONE  = 2'd3
    } sb_state_e;

    // Width of the saturating pass counter.
    localparam int PASS_W    = 16;

    // Upper bounds for the slice helper: a flat bus is zero-extended to
    // MAX_BUS bits and a slice is returned in MAX_SLICE bits, and the caller
    // truncates to its own width. NUM_CH*WIDTH must not exceed MAX_BUS and
    // WIDTH must not exceed MAX_SLICE.
    localparam int MAX_BUS   = 1024;
    localparam int MAX_SLICE = 256;

    // Channel idx of a flat bus packed as {ch[N-1], ..., ch[1], ch[0]}.
    function automatic logic [MAX_SLICE-1:0] get_slice(
        input logic [MAX_BUS-1:0] flat,
        input int unsigned        idx,
        input int unsigned        width
    );
        return MAX_SLICE'(flat >> (idx * width));
    endfunction

endpackage

// File: rtl/multi_channel_scoreboard_if.sv
// Observation bundle between the monitored datapath and the scoreboard.
// Latency: n/a (wires only).
// Backpressure: none; the scoreboard is a passive observer.
// Ports (master = environment/bench, slave = scoreboard):
//   push/pop        per-channel enqueue/dequeue strobes
//   start/start_ch  capture request and channel to capture on
//   flat_data_in    enqueue data, flat_data_out head-of-FIFO data
//   armed, data_out_vld, prop_signal, mismatch, proto_err, pass_cnt  results
interface multi_channel_scoreboard_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int SELW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

    logic [NUM_CH-1:0]         push;
    logic [NUM_CH-1:0]         pop;
    logic                      start;
    logic [SELW-1:0]           start_ch;
    logic [NUM_CH*WIDTH-1:0]   flat_data_in;
    logic [NUM_CH*WIDTH-1:0]   flat_data_out;

    logic                      armed;
    logic                      data_out_vld;
    logic                      prop_signal;
    logic                      mismatch;
    logic [NUM_CH-1:0]         proto_err;
    logic [sb_pkg::PASS_W-1:0] pass_cnt;

    modport master (
        output push, pop, start, start_ch, flat_data_in, flat_data_out,
        input  armed, data_out_vld, prop_signal, mismatch, proto_err, pass_cnt
    );

    modport slave (
        input  push, pop, start, start_ch, flat_data_in, flat_data_out,
        output armed, data_out_vld, prop_signal, mismatch, proto_err, pass_cnt
    );

endinterface

// File: rtl/multi_channel_scoreboard_occ_counter.sv
// Per-channel FIFO occupancy counter with sticky protocol-violation flag.
// Latency: legality strobes combinational; occupancy/flag update next edge.
// Backpressure: none; illegal strobes are dropped and flagged.
// Ports: clk, rst (async active-high), i_push, i_pop strobes;
//        o_occ occupancy, o_push_ok/o_pop_ok legal-strobe qualifiers,
//        o_proto_err sticky push-on-full / pop-on-empty flag.
module sb_occ_counter #(
    parameter int DEPTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    output logic [CNTWID-1:0] o_occ,
    output logic              o_push_ok,
    output logic              o_pop_ok,
    output logic              o_proto_err
);

    logic [CNTWID-1:0] r_occ;
    logic              r_err;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_pop_ok;

    // Full is judged on the current count only: a push into a full FIFO is
    // illegal even if a pop in the same cycle would have made room.
    assign w_full    = (r_occ == CNTWID'(DEPTH));
    assign w_empty   = (r_occ == '0);
    assign w_push_ok = i_push & ~w_full;
    assign w_pop_ok  = i_pop  & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
            r_err <= 1'b0;
        end else begin
            r_occ <= r_occ + CNTWID'(w_push_ok) - CNTWID'(w_pop_ok);
            if ((i_push & w_full) | (i_pop & w_empty)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_occ       = r_occ;
    assign o_push_ok   = w_push_ok;
    assign o_pop_ok    = w_pop_ok;
    assign o_proto_err = r_err;

endmodule

// File: rtl/multi_channel_scoreboard.sv
// Magic-packet scoreboard: tracks one tagged packet through a channel FIFO.
// Latency: exit flag/prop combinational; sticky flags and pass_cnt next edge.
// Backpressure: none; passive observer of push/pop/data streams.
// Ports: clk, rst (async active-high); bus (slave modport) carries the
//        observed strobes/data, the start request and all result outputs.
module multi_channel_scoreboard
    import sb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1,
    parameter bit REARM  = 1'b1,
    parameter int SELW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    multi_channel_scoreboard_if.slave  bus
);

    // ------------------------------------------------------------------
    // Per-channel occupancy
    // ------------------------------------------------------------------
    logic [CNTWID-1:0] w_occ  [NUM_CH];
    logic [WIDTH-1:0]  w_din  [NUM_CH];
    logic [WIDTH-1:0]  w_dout [NUM_CH];
    logic [NUM_CH-1:0] w_push_ok;
    logic [NUM_CH-1:0] w_pop_ok;
    logic [NUM_CH-1:0] w_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        sb_occ_counter #(
            .DEPTH  (DEPTH),
            .CNTWID (CNTWID)
        ) u_occ (
            .clk         (clk),
            .rst         (rst),
            .i_push      (bus.push[gi]),
            .i_pop       (bus.pop[gi]),
            .o_occ       (w_occ[gi]),
            .o_push_ok   (w_push_ok[gi]),
            .o_pop_ok    (w_pop_ok[gi]),
            .o_proto_err (w_err[gi])
        );

        assign w_din[gi]  = WIDTH'(get_slice(MAX_BUS'(bus.flat_data_in),  gi, WIDTH));
        assign w_dout[gi] = WIDTH'(get_slice(MAX_BUS'(bus.flat_data_out), gi, WIDTH));
    end

    // ------------------------------------------------------------------
    // Selected-channel view
    // ------------------------------------------------------------------
    sb_state_e         r_state;
    sb_state_e         w_state_nxt;
    logic [SELW-1:0]   r_sel;
    logic [WIDTH-1:0]  r_magic;
    logic [CNTWID-1:0] r_pos;
    logic              r_mismatch;
    logic [PASS_W-1:0] r_pass_cnt;

    logic              w_sel_push_ok;
    logic              w_sel_pop_ok;
    logic [CNTWID-1:0] w_sel_occ;
    logic [WIDTH-1:0]  w_sel_din;
    logic [WIDTH-1:0]  w_sel_dout;
    logic [CNTWID-1:0] w_pos_init;

    // Compare-select rather than array indexing so a sel value beyond
    // NUM_CH-1 (non power-of-two channel counts) simply selects nothing.
    always_comb begin
        w_sel_push_ok = 1'b0;
        w_sel_pop_ok  = 1'b0;
        w_sel_occ     = '0;
        w_sel_din     = '0;
        w_sel_dout    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_sel == SELW'(i)) begin
                w_sel_push_ok = w_push_ok[i];
                w_sel_pop_ok  = w_pop_ok[i];
                w_sel_occ     = w_occ[i];
                w_sel_din     = w_din[i];
                w_sel_dout    = w_dout[i];
            end
        end
    end

    // Position of the new packet counted from the head, after this cycle's
    // pop has removed its entry. A legal pop implies occ>=1, so no underflow.
    assign w_pos_init = w_sel_occ - CNTWID'(w_sel_pop_ok) + CNTWID'(1);

    // ------------------------------------------------------------------
    // Tracking FSM
    // ------------------------------------------------------------------
    logic w_start_acc;
    logic w_capture;
    logic w_exit;
    logic w_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_capture   = 1'b0;
        w_exit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_sel_push_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_sel_pop_ok && (r_pos == CNTWID'(1))) begin
                    w_exit      = 1'b1;
                    w_state_nxt = REARM ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_match = (w_sel_dout == r_magic);

    // ------------------------------------------------------------------
    // Capture, position tracking and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel      <= '0;
            r_magic    <= '0;
            r_pos      <= '0;
            r_mismatch <= 1'b0;
            r_pass_cnt <= '0;
        end else begin
            if (w_start_acc) begin
                r_sel <= bus.start_ch;
            end

            if (w_capture) begin
                r_magic <= w_sel_din;
                r_pos   <= w_pos_init;
            end else if (w_exit) begin
                r_pos <= '0;
            end else if ((r_state == ST_TRACK) && w_sel_pop_ok) begin
                r_pos <= r_pos - CNTWID'(1);
            end

            if (w_exit && !w_match) begin
                r_mismatch <= 1'b1;
            end

            if (w_exit && w_match && (r_pass_cnt != '1)) begin
                r_pass_cnt <= r_pass_cnt + PASS_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.armed        = (r_state == ST_WAIT) || (r_state == ST_TRACK);
    assign bus.data_out_vld = w_exit;
    assign bus.prop_signal  = ~w_exit | w_match;
    assign bus.mismatch     = r_mismatch;
    assign bus.proto_err    = w_err;
    assign bus.pass_cnt     = r_pass_cnt;

endmodule
